mpu_ls_controller: RTL and testbench

- Command sequencer for the MPU load/store path. Accepts one matrix operation at a time: NOP, LOAD or STORE plus a matrix register address.
- Drives the enables of the load and store units, which in turn access the matrix register file, and waits for their completion.
- Keeps a per-register valid scoreboard and returns a one-cycle status response per command.
- Sits between the MPU top-level command interface and the load/store units.

---
 rtl/mpu_ls_controller_if.sv | 44 ++++
 rtl/mpu_ls_controller.sv | 166 ++++++++++++++++
 tb/tb_mpu_ls_controller.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mpu_ls_controller_if.sv
// ============================================================================
// Module   : mpu_ls_controller_if
// Brief    : Command, load/store-unit and response bundle of the MPU LS controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mpu_ls_controller_if #(
   parameter int MATRIX_REGISTERS = 8,
   parameter int MATRIX_REG_SIZE  = 3
);
   logic                        cmd_valid_in;
   logic                        cmd_ready_out;
   logic [1:0]                  cmd_op_in;
   logic [MATRIX_REG_SIZE-1:0]  cmd_addr_in;
   logic                        load_en_out;
   logic [MATRIX_REG_SIZE-1:0]  load_addr_out;
   logic                        load_done_in;
   logic                        load_error_in;
   logic                        store_en_out;
   logic [MATRIX_REG_SIZE-1:0]  store_addr_out;
   logic                        store_done_in;
   logic                        resp_valid_out;
   logic [1:0]                  resp_status_out;
   logic [MATRIX_REGISTERS-1:0] reg_valid_out;
   logic                        busy_out;

   // master is the controller side; slave is the command source plus load/store units
   modport master (
      input  cmd_valid_in, cmd_op_in, cmd_addr_in,
      input  load_done_in, load_error_in, store_done_in,
      output cmd_ready_out, load_en_out, load_addr_out, store_en_out, store_addr_out,
      output resp_valid_out, resp_status_out, reg_valid_out, busy_out
   );

   modport slave (
      output cmd_valid_in, cmd_op_in, cmd_addr_in,
      output load_done_in, load_error_in, store_done_in,
      input  cmd_ready_out, load_en_out, load_addr_out, store_en_out, store_addr_out,
      input  resp_valid_out, resp_status_out, reg_valid_out, busy_out
   );
endinterface

`default_nettype wire

// File: rtl/mpu_ls_controller.sv
// ============================================================================
// Module   : mpu_ls_controller
// Brief    : Load/store command sequencer with register-valid scoreboard and timeout
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_ls_controller #(
   parameter int MATRIX_REGISTERS = 8,
   parameter int MATRIX_REG_SIZE  = 3,
   parameter int TIMEOUT_CYCLES   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   mpu_ls_controller_if.master  bus
);

   localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int c_slots = 1 << MATRIX_REG_SIZE;

   localparam logic [1:0] c_op_nop   = 2'd0;
   localparam logic [1:0] c_op_load  = 2'd1;
   localparam logic [1:0] c_op_store = 2'd2;

   localparam logic [1:0] c_st_ok         = 2'd0;
   localparam logic [1:0] c_st_not_loaded = 2'd1;
   localparam logic [1:0] c_st_timeout    = 2'd2;
   localparam logic [1:0] c_st_illegal    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_LOAD_WAIT  = 2'd1,
      S_STORE_WAIT = 2'd2,
      S_RESP       = 2'd3
   } state_t;

   state_t                     r_state;
   logic [c_cnt_w-1:0]         r_cnt;
   logic [c_slots-1:0]         r_reg_valid;
   logic                       r_cmd_ready;
   logic                       r_load_en;
   logic [MATRIX_REG_SIZE-1:0] r_load_addr;
   logic                       r_store_en;
   logic [MATRIX_REG_SIZE-1:0] r_store_addr;
   logic                       r_resp_valid;
   logic [1:0]                 r_resp_status;
   logic                       r_busy;

   logic w_accept;
   logic w_addr_legal;
   logic w_expired;

   assign w_accept     = bus.cmd_valid_in & r_cmd_ready;
   assign w_addr_legal = 32'(bus.cmd_addr_in) < 32'(MATRIX_REGISTERS);
   assign w_expired    = (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_reg_valid   <= '0;
         r_cmd_ready   <= 1'b1;
         r_load_en     <= 1'b0;
         r_load_addr   <= '0;
         r_store_en    <= 1'b0;
         r_store_addr  <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_status <= c_st_ok;
         r_busy        <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt       <= '0;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (bus.cmd_op_in == c_op_nop) begin
                     r_state       <= S_RESP;
                     r_resp_valid  <= 1'b1;
                     r_resp_status <= c_st_ok;
                  end else if (bus.cmd_op_in != c_op_load && bus.cmd_op_in != c_op_store
                               || !w_addr_legal) begin
                     r_state       <= S_RESP;
                     r_resp_valid  <= 1'b1;
                     r_resp_status <= c_st_illegal;
                  end else if (bus.cmd_op_in == c_op_load) begin
                     // A reload invalidates the register until the new data is complete
                     r_state                   <= S_LOAD_WAIT;
                     r_load_en                 <= 1'b1;
                     r_load_addr               <= bus.cmd_addr_in;
                     r_reg_valid[bus.cmd_addr_in] <= 1'b0;
                  end else if (!r_reg_valid[bus.cmd_addr_in]) begin
                     r_state       <= S_RESP;
                     r_resp_valid  <= 1'b1;
                     r_resp_status <= c_st_not_loaded;
                  end else begin
                     r_state      <= S_STORE_WAIT;
                     r_store_en   <= 1'b1;
                     r_store_addr <= bus.cmd_addr_in;
                  end
               end
            end

            S_LOAD_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // Error outranks done, and done outranks an expiring timeout
               if (bus.load_error_in) begin
                  r_state       <= S_RESP;
                  r_load_en     <= 1'b0;
                  r_resp_valid  <= 1'b1;
                  r_resp_status <= c_st_illegal;
               end else if (bus.load_done_in) begin
                  r_state                  <= S_RESP;
                  r_load_en                <= 1'b0;
                  r_resp_valid             <= 1'b1;
                  r_resp_status            <= c_st_ok;
                  r_reg_valid[r_load_addr] <= 1'b1;
               end else if (w_expired) begin
                  r_state       <= S_RESP;
                  r_load_en     <= 1'b0;
                  r_resp_valid  <= 1'b1;
                  r_resp_status <= c_st_timeout;
               end
            end

            S_STORE_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (bus.store_done_in || w_expired) begin
                  r_state       <= S_RESP;
                  r_store_en    <= 1'b0;
                  r_resp_valid  <= 1'b1;
                  r_resp_status <= bus.store_done_in ? c_st_ok : c_st_timeout;
               end
            end

            S_RESP: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
            end

            default: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_load_en   <= 1'b0;
               r_store_en  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready_out   = r_cmd_ready;
   assign bus.load_en_out     = r_load_en;
   assign bus.load_addr_out   = r_load_addr;
   assign bus.store_en_out    = r_store_en;
   assign bus.store_addr_out  = r_store_addr;
   assign bus.resp_valid_out  = r_resp_valid;
   assign bus.resp_status_out = r_resp_status;
   assign bus.reg_valid_out   = r_reg_valid[MATRIX_REGISTERS-1:0];
   assign bus.busy_out        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mpu_ls_controller.sv
// ============================================================================
// Module   : tb_mpu_ls_controller
// Brief    : Directed and randomized self-checking bench for mpu_ls_controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpu_ls_controller;

   localparam int NREG = 8;
   localparam int AW   = 3;
   localparam int TMO  = 64;

   localparam int OP_NOP = 0, OP_LOAD = 1, OP_STORE = 2, OP_MULT = 3;
   localparam int ST_OK = 0, ST_NOT_LOADED = 1, ST_TIMEOUT = 2, ST_ILLEGAL = 3;
   localparam int U_NONE = 0, U_LOAD = 1, U_STORE = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   bit   model_valid [NREG];

   mpu_ls_controller_if #(.MATRIX_REGISTERS(NREG), .MATRIX_REG_SIZE(AW)) bus ();

   mpu_ls_controller #(
      .MATRIX_REGISTERS (NREG),
      .MATRIX_REG_SIZE  (AW),
      .TIMEOUT_CYCLES   (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_bits();
      logic [31:0] v = '0;
      for (int i = 0; i < NREG; i++) v[i] = model_valid[i];
      return v;
   endfunction

   // Outcome of one command: a done raised during the delay-th enable cycle ends it,
   // delay 0 or beyond the timeout means the enable runs the full TMO cycles.
   function automatic void predict(input int op, input int addr, input int delay, input bit err,
                                   output int status, output int len, output int unit);
      bit in_time = (delay >= 1) && (delay <= TMO);
      unit = U_NONE;
      len  = 0;
      status = ST_OK;
      case (op)
         OP_NOP:  status = ST_OK;
         OP_MULT: status = ST_ILLEGAL;
         OP_LOAD: begin
            unit = U_LOAD;
            model_valid[addr] = 1'b0;
            len    = in_time ? delay : TMO;
            status = !in_time ? ST_TIMEOUT : (err ? ST_ILLEGAL : ST_OK);
            if (in_time && !err) model_valid[addr] = 1'b1;
         end
         default: begin
            if (!model_valid[addr]) status = ST_NOT_LOADED;
            else begin
               unit   = U_STORE;
               len    = in_time ? delay : TMO;
               status = in_time ? ST_OK : ST_TIMEOUT;
            end
         end
      endcase
   endfunction

   task automatic run_cmd(input string tag, input int op, input int addr, input int delay,
                          input bit err);
      int st, len, unit, en_cnt;
      bit got, wrong_en, addr_bad, not_busy;
      predict(op, addr, delay, err, st, len, unit);
      check({tag, ":ready"}, 32'(bus.cmd_ready_out), 32'd1);
      bus.cmd_valid_in = 1'b1;
      bus.cmd_op_in    = 2'(op);
      bus.cmd_addr_in  = AW'(addr);
      @(negedge clk);
      en_cnt = 0; got = 0; wrong_en = 0; addr_bad = 0; not_busy = 0;
      for (int k = 1; k <= TMO + 20 && !got; k++) begin
         if (bus.resp_valid_out) begin
            got = 1'b1;
            bus.cmd_valid_in  = 1'b0;
            bus.load_done_in  = 1'b0;
            bus.store_done_in = 1'b0;
            bus.load_error_in = 1'b0;
         end else begin
            if (unit == U_LOAD && bus.load_en_out) en_cnt++;
            if (unit == U_STORE && bus.store_en_out) en_cnt++;
            if (unit != U_LOAD && bus.load_en_out) wrong_en = 1'b1;
            if (unit != U_STORE && bus.store_en_out) wrong_en = 1'b1;
            if (bus.load_en_out && bus.load_addr_out != AW'(addr)) addr_bad = 1'b1;
            if (bus.store_en_out && bus.store_addr_out != AW'(addr)) addr_bad = 1'b1;
            if (!bus.busy_out || bus.cmd_ready_out) not_busy = 1'b1;
            // Both done strobes plus the error are raised; the idle unit's inputs must be ignored
            bus.cmd_valid_in  = 1'($urandom);
            bus.cmd_op_in     = 2'($urandom);
            bus.cmd_addr_in   = AW'($urandom);
            bus.load_done_in  = (k == delay);
            bus.store_done_in = (k == delay);
            bus.load_error_in = (k == delay) && err;
            @(negedge clk);
         end
      end
      check({tag, ":resp_seen"}, 32'(got), 32'd1);
      check({tag, ":en_cycles"}, 32'(en_cnt), 32'(len));
      check({tag, ":status"}, 32'(bus.resp_status_out), 32'(st));
      check({tag, ":en_in_resp"}, {30'd0, bus.load_en_out, bus.store_en_out}, 32'd0);
      check({tag, ":wrong_en"}, 32'(wrong_en), 32'd0);
      check({tag, ":en_addr"}, 32'(addr_bad), 32'd0);
      check({tag, ":busy"}, 32'(not_busy | !bus.busy_out), 32'd0);
      @(negedge clk);
      check({tag, ":resp_pulse"}, 32'(bus.resp_valid_out), 32'd0);
      check({tag, ":status_hold"}, 32'(bus.resp_status_out), 32'(st));
      check({tag, ":ready_again"}, 32'(bus.cmd_ready_out), 32'd1);
      check({tag, ":reg_valid"}, 32'(bus.reg_valid_out), model_bits());
   endtask

   initial begin
      int op, addr, delay, r;
      bit err;
      bus.cmd_valid_in  = 1'b0;
      bus.cmd_op_in     = 2'd0;
      bus.cmd_addr_in   = '0;
      bus.load_done_in  = 1'b0;
      bus.load_error_in = 1'b0;
      bus.store_done_in = 1'b0;
      for (int i = 0; i < NREG; i++) model_valid[i] = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst:ready", 32'(bus.cmd_ready_out), 32'd1);
      check("rst:outs", {25'd0, bus.load_en_out, bus.store_en_out, bus.resp_valid_out,
                         bus.busy_out, bus.resp_status_out, 1'b0}, 32'd0);
      check("rst:addrs", {26'd0, bus.load_addr_out, bus.store_addr_out}, 32'd0);
      check("rst:reg_valid", 32'(bus.reg_valid_out), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      run_cmd("nop", OP_NOP, 0, 0, 1'b0);
      run_cmd("load0", OP_LOAD, 0, 5, 1'b0);
      check("load0:vec", 32'(bus.reg_valid_out), 32'h01);
      run_cmd("store0", OP_STORE, 0, 9, 1'b0);
      run_cmd("store_unloaded", OP_STORE, 1, 3, 1'b0);
      run_cmd("mult", OP_MULT, 4, 2, 1'b0);
      run_cmd("load_err", OP_LOAD, 2, 3, 1'b1);
      run_cmd("load_timeout", OP_LOAD, 3, 0, 1'b0);
      run_cmd("load_race", OP_LOAD, 3, TMO, 1'b0);
      run_cmd("store_timeout", OP_STORE, 3, TMO + 1, 1'b0);

      // Reset in the middle of a store drops the enable at once and yields no response
      check("mid:ready", 32'(bus.cmd_ready_out), 32'd1);
      bus.cmd_valid_in = 1'b1;
      bus.cmd_op_in    = 2'(OP_STORE);
      bus.cmd_addr_in  = AW'(0);
      @(negedge clk);
      bus.cmd_valid_in = 1'b0;
      repeat (3) @(negedge clk);
      check("mid:store_en", 32'(bus.store_en_out), 32'd1);
      rst = 1'b0;
      #1;
      check("mid:store_en_drop", 32'(bus.store_en_out), 32'd0);
      check("mid:no_resp", 32'(bus.resp_valid_out), 32'd0);
      check("mid:reg_clear", 32'(bus.reg_valid_out), 32'd0);
      for (int i = 0; i < NREG; i++) model_valid[i] = 1'b0;
      @(negedge clk);
      check("mid:no_resp_later", 32'(bus.resp_valid_out), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      run_cmd("after_rst", OP_NOP, 0, 0, 1'b0);

      // Randomized commands; stray done/error strobes in IDLE must change nothing
      for (int n = 0; n < 40; n++) begin
         op   = int'($urandom_range(0, 9));
         op   = (op < 4) ? OP_LOAD : (op < 8) ? OP_STORE : (op == 8) ? OP_NOP : OP_MULT;
         addr = int'($urandom_range(0, NREG - 1));
         r    = int'($urandom_range(0, 9));
         delay = (r == 0) ? 0 : (r == 1) ? TMO - 1 + int'($urandom_range(0, 2))
                                         : int'($urandom_range(1, 12));
         err  = ($urandom_range(0, 3) == 0);
         bus.load_done_in  = 1'b1;
         bus.store_done_in = 1'b1;
         bus.load_error_in = 1'b1;
         @(negedge clk);
         bus.load_done_in  = 1'b0;
         bus.store_done_in = 1'b0;
         bus.load_error_in = 1'b0;
         run_cmd($sformatf("rnd%0d", n), op, addr, delay, err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
